// File: rtl/mdu_pipe.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional macro MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
module mdu_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic { S_IDLE = 1'b0, S_RUN = 1'b1 } state_e;
  // What happens to {hi,lo} when the countdown completes.
  typedef enum logic [1:0] { K_WR = 2'd0, K_SKIP = 2'd1, K_ADD = 2'd2, K_SUB = 2'd3 } kind_e;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b, sdiv_b, udiv_b;
  logic [WIDTH-1:0]   uq, ur, sq, sr, dq, dr;

  // Arithmetic datapath; divisors are forced nonzero so a divide-by-zero never yields X.
  always_comb begin
    prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    neg_a  = src_a[WIDTH-1];
    neg_b  = src_b[WIDTH-1];
    abs_a  = neg_a ? (WIDTH'(0) - src_a) : src_a;
    abs_b  = neg_b ? (WIDTH'(0) - src_b) : src_b;
    sdiv_b = (abs_b == WIDTH'(0)) ? WIDTH'(1) : abs_b;
    udiv_b = (src_b == WIDTH'(0)) ? WIDTH'(1) : src_b;
    // Magnitude divide; most-negative / -1 falls out as quotient 0x8..0, remainder 0.
    uq     = abs_a / sdiv_b;
    ur     = abs_a % sdiv_b;
    sq     = (neg_a ^ neg_b) ? (WIDTH'(0) - uq) : uq;
    sr     = neg_a ? (WIDTH'(0) - ur) : ur;
    dq     = src_a / udiv_b;
    dr     = src_a % udiv_b;
  end

  // Next-state, countdown, pending-result capture and HI/LO update.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT:  begin pend_d = prod_s; kind_d = K_WR; cnt_d = MULT_LD; state_d = S_RUN; end
            OP_MULTU: begin pend_d = prod_u; kind_d = K_WR; cnt_d = MULT_LD; state_d = S_RUN; end
            OP_DIV: begin
              pend_d  = {sr, sq};
              kind_d  = (src_b == WIDTH'(0)) ? K_SKIP : K_WR;
              cnt_d   = DIV_LD;
              state_d = S_RUN;
            end
            OP_DIVU: begin
              pend_d  = {dr, dq};
              kind_d  = (src_b == WIDTH'(0)) ? K_SKIP : K_WR;
              cnt_d   = DIV_LD;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
`ifdef MDU_MADD_EN
            OP_MADD:  begin pend_d = prod_s; kind_d = K_ADD; cnt_d = MULT_LD; state_d = S_RUN; end
            OP_MADDU: begin pend_d = prod_u; kind_d = K_ADD; cnt_d = MULT_LD; state_d = S_RUN; end
            OP_MSUB:  begin pend_d = prod_s; kind_d = K_SUB; cnt_d = MULT_LD; state_d = S_RUN; end
            OP_MSUBU: begin pend_d = prod_u; kind_d = K_SUB; cnt_d = MULT_LD; state_d = S_RUN; end
`endif
            default: begin end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = CW'(0);
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = CW'(0);
          case (kind_q)
            K_WR:  {hi_d, lo_d} = pend_q;
`ifdef MDU_MADD_EN
            K_ADD: {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
            K_SUB: {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
`endif
            default: begin end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_WR;
      cnt_q   <= CW'(0);
      pend_q  <= {(2*WIDTH){1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Randomized plus directed bench for mdu_pipe against an arithmetic reference model.
module tb_mdu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mdu_pipe #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: HI/LO, remaining busy cycles, pending result and its completion action.
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  int          m_left = 0;
  logic [63:0] m_pend = 64'h0;
  int          m_kind = 0;   // 0 write, 1 leave unchanged, 2 accumulate add, 3 accumulate sub

  task automatic model_edge();
    longint sa, sb;
    logic [63:0] q, r;
    if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          case (m_kind)
            0: {m_hi, m_lo} = m_pend;
            2: {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
            3: {m_hi, m_lo} = {m_hi, m_lo} - m_pend;
            default: begin end
          endcase
        end
      end
    end else if (start && !flush) begin
      sa = longint'($signed(src_a));
      sb = longint'($signed(src_b));
      case (op)
        4'd1: begin m_pend = sa * sb; m_kind = 0; m_left = 5; end
        4'd2: begin m_pend = {32'h0, src_a} * {32'h0, src_b}; m_kind = 0; m_left = 5; end
        4'd3: begin
          m_left = 10;
          if (src_b == 32'h0) m_kind = 1;
          else begin q = sa / sb; r = sa % sb; m_pend = {r[31:0], q[31:0]}; m_kind = 0; end
        end
        4'd4: begin
          m_left = 10;
          if (src_b == 32'h0) m_kind = 1;
          else begin m_pend = {src_a % src_b, src_a / src_b}; m_kind = 0; end
        end
        4'd5: m_hi = src_a;
        4'd6: m_lo = src_a;
`ifdef MDU_MADD_EN
        4'd7:  begin m_pend = sa * sb; m_kind = 2; m_left = 5; end
        4'd8:  begin m_pend = {32'h0, src_a} * {32'h0, src_b}; m_kind = 2; m_left = 5; end
        4'd9:  begin m_pend = sa * sb; m_kind = 3; m_left = 5; end
        4'd10: begin m_pend = {32'h0, src_a} * {32'h0, src_b}; m_kind = 3; m_left = 5; end
`endif
        default: begin end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy", {63'h0, busy}, {63'h0, (m_left > 0)});
    check("hi", {32'h0, hi}, {32'h0, m_hi});
    check("lo", {32'h0, lo}, {32'h0, m_lo});
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    cyc();
    start = 1'b0; op = 4'd0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [31:0] save_hi, save_lo;
  logic [31:0] rv;

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    reset = 1'b1;
    cyc();

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy1", {63'h0, busy}, 64'h1);
    idle_n(5);
    check("mult_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'h0, lo}, 64'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_n(4);
    check("multu_hold_hi", {32'h0, hi}, 64'hFFFF_FFFF);
    cyc();
    check("multu_hi", {32'h0, hi}, 64'hFFFF_FFFE);
    check("multu_lo", {32'h0, lo}, 64'h0000_0001);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    idle_n(10);
    check("div_lo", {32'h0, lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'h0, hi}, 64'hFFFF_FFFF);

    issue(4'd5, 32'h11, 32'h0);
    issue(4'd6, 32'h22, 32'h0);
    issue(4'd4, 32'h1234_5678, 32'h0);
    idle_n(9);
    check("divz_busy", {63'h0, busy}, 64'h1);
    cyc();
    check("divz_hi", {32'h0, hi}, 64'h11);
    check("divz_lo", {32'h0, lo}, 64'h22);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_n(10);
    check("divovf_lo", {32'h0, lo}, 64'h8000_0000);
    check("divovf_hi", {32'h0, hi}, 64'h0);

    issue(4'd6, 32'h1234, 32'h0);
    check("mtlo_lo", {32'h0, lo}, 64'h1234);
    check("mtlo_busy", {63'h0, busy}, 64'h0);

    save_hi = hi; save_lo = lo;
    issue(4'd1, 32'd3, 32'd3);
    issue(4'd5, 32'hDEAD, 32'h0);   // ignored while busy
    flush = 1'b1; cyc(); flush = 1'b0;
    check("flush_busy", {63'h0, busy}, 64'h0);
    check("flush_hi", {32'h0, hi}, {32'h0, save_hi});
    check("flush_lo", {32'h0, lo}, {32'h0, save_lo});

    flush = 1'b1; issue(4'd5, 32'hBEEF, 32'h0); flush = 1'b0;
    check("flush_start_hi", {32'h0, hi}, {32'h0, save_hi});

    issue(4'd2, 32'd7, 32'd9);
    idle_n(4);
    flush = 1'b1; cyc(); flush = 1'b0;
    check("flush_done_lo", {32'h0, lo}, {32'h0, save_lo});

    issue(4'd5, 32'h0, 32'h0);
    issue(4'd6, 32'hFFFF_FFFF, 32'h0);
    issue(4'd8, 32'd1, 32'd1);
    idle_n(5);
`ifdef MDU_MADD_EN
    check("maddu_hi", {32'h0, hi}, 64'h1);
    check("maddu_lo", {32'h0, lo}, 64'h0);
`else
    check("maddu_hi", {32'h0, hi}, 64'h0);
    check("maddu_lo", {32'h0, lo}, 64'hFFFF_FFFF);
`endif

    issue(4'd1, 32'd100, 32'd200);
    idle_n(2);
    reset = 1'b0;
    #1;
    m_hi = 32'h0; m_lo = 32'h0; m_left = 0;
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_hi", {32'h0, hi}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 15));
      rv    = $urandom;
      case ($urandom_range(0, 5))
        0: src_a = 32'h8000_0000;
        1: src_a = 32'($urandom_range(0, 20));
        default: src_a = rv;
      endcase
      case ($urandom_range(0, 5))
        0: src_b = 32'h0;
        1: src_b = 32'hFFFF_FFFF;
        2: src_b = 32'($urandom_range(1, 20));
        default: src_b = $urandom;
      endcase
      flush = ($urandom_range(0, 19) == 0);
      cyc();
    end
    start = 1'b0; flush = 1'b0;
    idle_n(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
